// File: rtl/montacarga_pkg.sv
// Shared types and constants for the montacarga_ctrl freight-elevator controller.
package montacarga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UP     = 3'd1,
    ST_DOWN   = 3'd2,
    ST_DWELL  = 3'd3,
    ST_EMERG  = 3'd4,
    ST_HOMING = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b10;
  localparam logic [1:0] MOTOR_DOWN = 2'b01;

  // Segment patterns, bit order gfedcba, active-high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational floor-index to 7-segment digit decoder (index 0 shows "1").
module seg7_decoder
  import montacarga_pkg::*;
#(
  parameter int FLOOR_W = 3
) (
  input  logic [FLOOR_W-1:0] piso,
  output logic [6:0]         segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (int'(piso))
      0:       segments = SEG_1;
      1:       segments = SEG_2;
      2:       segments = SEG_3;
      3:       segments = SEG_4;
      4:       segments = SEG_5;
      5:       segments = SEG_6;
      6:       segments = SEG_7;
      7:       segments = SEG_8;
      8:       segments = SEG_9;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/montacarga_ctrl.sv
// Multi-call SCAN freight-elevator controller with door dwell, emergency stop and homing.
// Optional travel watchdog compiled in with MONTACARGA_TIMEOUT_EN.
module montacarga_ctrl
  import montacarga_pkg::*;
#(
  parameter int FLOORS         = 5,
  parameter int DOOR_TICKS     = 4,
  parameter int TRAVEL_TIMEOUT = 64,
  parameter int FLOOR_W        = $clog2(FLOORS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  selector,
  input  logic [FLOORS-1:0]  fc,
  input  logic               emergencia,
  input  logic               puerta,
  output logic [1:0]         salida,
  output logic               led_emergencia,
  output logic               led_puerta,
  output logic [6:0]         display,
  output logic               tr,
  output logic [FLOORS-1:0]  pending,
  output logic [FLOOR_W-1:0] piso,
  output logic [2:0]         fsm_state
);

  // Handshake: none. All inputs are levels sampled every rising clk edge;
  // all outputs are registered and change only on rising clk edges.

  localparam int               CNT_W      = $clog2(DOOR_TICKS + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DOOR_TICKS - 1);

  // Unsupported parameter sets show up as this empty scope in the hierarchy.
  if (FLOORS < 2 || FLOORS > 9 || DOOR_TICKS < 1 || TRAVEL_TIMEOUT < 1) begin : g_bad_config
  end

  state_t             state_q, state_d;
  logic               dir_up_q, dir_up_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLOOR_W-1:0] piso_d;
  logic [FLOORS-1:0]  pending_d, sel_map, clear_mask;
  logic [1:0]         salida_d;
  logic [6:0]         seg_d;
  logic               latch_en, clear_all, hold, fault_hit;
  logic               fc_any;
  logic [FLOOR_W-1:0] fc_idx;
  logic               calls_above, calls_below;

  function automatic logic any_beyond(input logic [FLOORS-1:0]  calls,
                                      input logic [FLOOR_W-1:0] f,
                                      input logic               above);
    logic [FLOORS-1:0] mask;
    mask = '0;
    for (int i = 0; i < FLOORS; i++)
      mask[i] = above ? (i > int'(f)) : (i < int'(f));
    return |(calls & mask);
  endfunction

  // Buttons arrive MSB = floor 1; internally bit k is floor k+1.
  always_comb begin
    sel_map = '0;
    for (int k = 0; k < FLOORS; k++)
      sel_map[k] = selector[FLOORS-1-k];
  end

  // Lowest asserted limit switch wins when several read high.
  always_comb begin
    fc_any = |fc;
    fc_idx = '0;
    for (int i = FLOORS - 1; i >= 0; i--)
      if (fc[i]) fc_idx = FLOOR_W'(i);
  end

  assign calls_above = any_beyond(pending, piso, 1'b1);
  assign calls_below = any_beyond(pending, piso, 1'b0);

`ifdef MONTACARGA_TIMEOUT_EN
  localparam int WD_W = $clog2(TRAVEL_TIMEOUT + 1);
  logic [FLOORS-1:0] fc_prev;
  logic [WD_W-1:0]   wd_q;
  logic              fc_rise, motor_on;

  assign fc_rise   = |(fc & ~fc_prev);
  assign motor_on  = (salida != MOTOR_STOP);
  assign fault_hit = motor_on && !fc_rise && (wd_q == WD_W'(TRAVEL_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      fc_prev <= '0;
      wd_q    <= '0;
    end else begin
      fc_prev <= fc;
      if (fc_rise || !motor_on || fault_hit) wd_q <= '0;
      else                                   wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  assign fault_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dir_up_d   = dir_up_q;
    cnt_d      = cnt_q;
    piso_d     = piso;
    clear_mask = '0;
    clear_all  = 1'b0;
    latch_en   = 1'b1;
    hold       = 1'b0;
    if (state_q == ST_FAULT) begin
      clear_all = 1'b1;
      latch_en  = 1'b0;
    end else if (fault_hit) begin
      state_d   = ST_FAULT;
      clear_all = 1'b1;
      latch_en  = 1'b0;
    end else if (emergencia) begin
      state_d   = ST_EMERG;
      clear_all = 1'b1;
      latch_en  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!puerta) begin
            if (pending[piso]) begin
              state_d          = ST_DWELL;
              cnt_d            = '0;
              clear_mask[piso] = 1'b1;
            end else if (calls_above) begin
              state_d  = ST_UP;
              dir_up_d = 1'b1;
            end else if (calls_below) begin
              state_d  = ST_DOWN;
              dir_up_d = 1'b0;
            end
          end
        end
        ST_UP, ST_DOWN: begin
          if (puerta) begin
            hold = 1'b1;
          end else if (fc_any) begin
            piso_d = fc_idx;
            if (pending[fc_idx]) begin
              state_d            = ST_DWELL;
              cnt_d              = '0;
              clear_mask[fc_idx] = 1'b1;
            end
          end
        end
        ST_DWELL: begin
          if (!puerta) begin
            if (cnt_q == DWELL_LAST) begin
              // SCAN: keep heading while work remains ahead, else turn around.
              if (dir_up_q && calls_above)       state_d = ST_UP;
              else if (!dir_up_q && calls_below) state_d = ST_DOWN;
              else if (calls_above) begin
                state_d  = ST_UP;
                dir_up_d = 1'b1;
              end else if (calls_below) begin
                state_d  = ST_DOWN;
                dir_up_d = 1'b0;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_EMERG: begin
          latch_en = 1'b0;
          if (fc[0]) begin
            state_d = ST_IDLE;
            piso_d  = '0;
          end else begin
            state_d = ST_HOMING;
          end
        end
        ST_HOMING: begin
          latch_en = 1'b0;
          if (fc[0]) begin
            state_d = ST_IDLE;
            piso_d  = '0;
          end
        end
        default: begin
          state_d   = ST_FAULT;
          clear_all = 1'b1;
          latch_en  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    salida_d = MOTOR_STOP;
    if (!hold) begin
      case (state_d)
        ST_UP:             salida_d = MOTOR_UP;
        ST_DOWN, ST_HOMING: salida_d = MOTOR_DOWN;
        default:           salida_d = MOTOR_STOP;
      endcase
    end
  end

  // Clearing after the OR means a press on the floor being served is dropped.
  assign pending_d = clear_all ? '0
                   : ((pending | (latch_en ? sel_map : '0)) & ~clear_mask);

  seg7_decoder #(.FLOOR_W(FLOOR_W)) u_seg7 (
    .piso     (piso_d),
    .segments (seg_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      dir_up_q       <= 1'b1;
      cnt_q          <= '0;
      piso           <= '0;
      pending        <= '0;
      salida         <= MOTOR_STOP;
      tr             <= 1'b0;
      led_emergencia <= 1'b0;
      led_puerta     <= 1'b0;
      display        <= SEG_1;
    end else begin
      state_q        <= state_d;
      dir_up_q       <= dir_up_d;
      cnt_q          <= cnt_d;
      piso           <= piso_d;
      pending        <= pending_d;
      salida         <= salida_d;
      tr             <= (salida_d != MOTOR_STOP);
      led_emergencia <= (state_d == ST_EMERG) || (state_d == ST_HOMING) || (state_d == ST_FAULT);
      led_puerta     <= (state_d == ST_DWELL) ||
                        (puerta && ((state_d == ST_IDLE) || (state_d == ST_UP) || (state_d == ST_DOWN)));
      display        <= seg_d;
    end
  end

  assign fsm_state = state_q;

endmodule
